// File: rtl/scroll_text_loader.sv
// rtl/scroll_text_loader.sv - buffers an ASCII message and scrolls it across a 16-segment display.
module scroll_text_loader #(
  parameter int MSG_DEPTH  = 32,
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       clear,
  output logic [7:0] char_out,
  output logic       char_load,
  output logic [2:0] char_addr,
  output logic       busy,
  output logic [5:0] msg_len
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS);
  localparam int SW = PW + 1;
  localparam int WW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REFRESH, S_WAIT, S_BLANK} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      len_q, len_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [2:0]      dig_q, dig_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic            in_ready_q, busy_q, char_load_q;
  logic [7:0]      char_out_q;
  logic [2:0]      char_addr_q;

  logic [7:0]      msg_mem [MSG_DEPTH];
  logic [7:0]      wr_data;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic            take, commit, load_d;
  logic [SW-1:0]   span_q, span_d, idx;
  logic [7:0]      char_d;

  always_comb begin
    wr_data = in_char;
    if (in_char >= 8'h61 && in_char <= 8'h7a) wr_data = in_char - 8'h20;
    take   = in_valid && in_ready_q && !clear;
    commit = take && (in_last || cnt_q == 6'(MSG_DEPTH - 1));
    wr_idx = (state_q == S_IDLE) ? '0 : cnt_q[AW-1:0];
    span_q = SW'(len_q) + SW'(NUM_DIGITS);

    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pos_d   = pos_q;
    dig_d   = dig_q;
    wait_d  = wait_q;

    if (clear) begin
      state_d = S_BLANK;
      dig_d   = '0;
      cnt_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (take) begin
            if (commit) begin
              len_d   = cnt_q + 6'd1;
              pos_d   = '0;
              dig_d   = '0;
              cnt_d   = '0;
              state_d = S_REFRESH;
            end else begin
              cnt_d   = cnt_q + 6'd1;
              state_d = S_LOAD;
            end
          end
        end
        S_REFRESH: begin
          if (dig_q == 3'(NUM_DIGITS - 1)) begin
            state_d = S_WAIT;
            wait_d  = '0;
          end else begin
            dig_d = dig_q + 3'd1;
          end
        end
        S_WAIT: begin
          if (wait_q == WW'(SCROLL_DIV - 1)) begin
            wait_d  = '0;
            dig_d   = '0;
            state_d = S_REFRESH;
            pos_d   = (SW'(pos_q) + SW'(1) >= span_q) ? '0 : pos_q + PW'(1);
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_BLANK: begin
          if (dig_q == 3'(NUM_DIGITS - 1)) begin
            state_d = S_IDLE;
            len_d   = '0;
            dig_d   = '0;
          end else begin
            dig_d = dig_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are computed from next-state values so each digit appears the cycle its state is entered.
    span_d = SW'(len_d) + SW'(NUM_DIGITS);
    idx    = SW'(pos_d) + SW'(dig_d);
    if (idx >= span_d) idx = idx - span_d;
    rd_idx = idx[AW-1:0];
    char_d = 8'h20;
    // A one-character message commits on the same edge it is written, so bypass the memory.
    if (state_d == S_REFRESH && idx < SW'(len_d))
      char_d = (take && rd_idx == wr_idx) ? wr_data : msg_mem[rd_idx];
    load_d = (state_d == S_REFRESH) || (state_d == S_BLANK);
  end

  always_ff @(posedge clk) begin
    if (take) msg_mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      pos_q       <= '0;
      dig_q       <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      char_load_q <= 1'b0;
      char_out_q  <= 8'h00;
      char_addr_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      dig_q       <= dig_d;
      wait_q      <= wait_d;
      in_ready_q  <= (state_d == S_IDLE) || (state_d == S_LOAD);
      busy_q      <= (state_d == S_REFRESH) || (state_d == S_WAIT) || (state_d == S_BLANK);
      char_load_q <= load_d;
      if (load_d) begin
        char_out_q  <= char_d;
        char_addr_q <= dig_d;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign char_load = char_load_q;
  assign char_out  = char_out_q;
  assign char_addr = char_addr_q;
  assign msg_len   = len_q;

endmodule

// File: tb/tb_scroll_text_loader.sv
// tb/tb_scroll_text_loader.sv - directed self-checking bench for scroll_text_loader.
module tb_scroll_text_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_char;
  logic       in_valid, in_last, clear;
  logic       in_ready, char_load, busy;
  logic [7:0] char_out;
  logic [2:0] char_addr;
  logic [5:0] msg_len;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] fr_ch [6];
  logic [2:0] fr_ad [6];
  bit         fr_ok;
  int         fr_cyc;

  scroll_text_loader #(.MSG_DEPTH(32), .NUM_DIGITS(6), .SCROLL_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_char(in_char), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .clear(clear), .char_out(char_out), .char_load(char_load),
    .char_addr(char_addr), .busy(busy), .msg_len(msg_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] fr_text();
    return {fr_ch[0], fr_ch[1], fr_ch[2], fr_ch[3], fr_ch[4], fr_ch[5]};
  endfunction

  function automatic logic [17:0] fr_addr();
    return {fr_ad[0], fr_ad[1], fr_ad[2], fr_ad[3], fr_ad[4], fr_ad[5]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] c, input logic last);
    in_char = c; in_valid = 1'b1; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Collect six consecutive digit writes; fr_ok drops on timeout or a gap.
  task automatic grab_frame();
    int n = 0;
    fr_ok = 1'b0;
    while (char_load !== 1'b1 && n < 200) begin tick(); n++; end
    if (char_load === 1'b1) begin
      fr_ok = 1'b1; fr_cyc = cyc;
      for (int i = 0; i < 6; i++) begin
        if (char_load !== 1'b1) fr_ok = 1'b0;
        fr_ch[i] = char_out; fr_ad[i] = char_addr;
        tick();
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_char = 8'h00; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
    checks++; if (char_load !== 1'b0) $display("FAIL reset_char_load got=%b want=0", char_load); else passed++;
    checks++; if (char_out !== 8'h00 || char_addr !== 3'd0) $display("FAIL reset_char got=%h/%0d want=00/0", char_out, char_addr); else passed++;
    checks++; if (busy !== 1'b0 || msg_len !== 6'd0) $display("FAIL reset_busy_len got=%b/%0d want=0/0", busy, msg_len); else passed++;
  endtask

  task automatic test_short_msg();
    logic [47:0] exp;
    int c0, c1;
    send_byte("h", 1'b0);
    send_byte("I", 1'b1);
    c0 = cyc;
    checks++; if (msg_len !== 6'd2 || busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL short_commit len=%0d busy=%b rdy=%b want 2/1/0", msg_len, busy, in_ready); else passed++;
    grab_frame();
    exp = "HI    ";
    checks++; if (!fr_ok || fr_cyc != c0 || fr_text() !== exp || fr_addr() !== 18'o012345) $display("FAIL short_step0 ok=%0d start=%0d text=%h addr=%o want start=%0d text=%h addr=012345", fr_ok, fr_cyc, fr_text(), fr_addr(), c0, exp); else passed++;
    for (int s = 1; s <= 8; s++) begin
      grab_frame();
      if (s == 1) begin
        c1 = fr_cyc; exp = "I     ";
        checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL short_step1 text=%h want=%h", fr_text(), exp); else passed++;
        checks++; if (c1 - c0 != 10) $display("FAIL short_period got=%0d want=10", c1 - c0); else passed++;
      end else if (s == 7) begin
        exp = " HI   ";
        checks++; if (!fr_ok || fr_text() !== exp || fr_addr() !== 18'o012345) $display("FAIL short_step7 text=%h addr=%o want=%h", fr_text(), fr_addr(), exp); else passed++;
      end else if (s == 8) begin
        exp = "HI    ";
        checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL short_wrap text=%h want=%h", fr_text(), exp); else passed++;
      end
    end
  endtask

  task automatic test_hold_valid();
    logic [47:0] exp;
    in_char = "z"; in_valid = 1'b1; in_last = 1'b1;
    grab_frame();
    exp = "I     ";
    checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL hold_frame text=%h want=%h", fr_text(), exp); else passed++;
    checks++; if (in_ready !== 1'b0 || msg_len !== 6'd2) $display("FAIL hold_ready_len rdy=%b len=%0d want 0/2", in_ready, msg_len); else passed++;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_clear();
    logic [47:0] exp;
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (char_load !== 1'b1 || char_addr !== 3'd0 || char_out !== 8'h20) $display("FAIL clear_first load=%b addr=%0d out=%h want 1/0/20", char_load, char_addr, char_out); else passed++;
    grab_frame();
    exp = "      ";
    checks++; if (!fr_ok || fr_text() !== exp || fr_addr() !== 18'o012345) $display("FAIL clear_blank text=%h addr=%o want=%h", fr_text(), fr_addr(), exp); else passed++;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || msg_len !== 6'd0 || char_load !== 1'b0) $display("FAIL clear_idle rdy=%b busy=%b len=%0d load=%b want 1/0/0/0", in_ready, busy, msg_len, char_load); else passed++;
  endtask

  task automatic test_single_char();
    logic [47:0] exp;
    send_byte("q", 1'b1);
    checks++; if (msg_len !== 6'd1 || char_load !== 1'b1) $display("FAIL single_commit len=%0d load=%b want 1/1", msg_len, char_load); else passed++;
    grab_frame();
    exp = "Q     ";
    checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL single_frame text=%h want=%h", fr_text(), exp); else passed++;
    do_clear();
  endtask

  task automatic test_overflow();
    logic [47:0] exp;
    for (int i = 0; i < 32; i++) begin
      if (i < 26) send_byte(8'(8'h61 + i), 1'b0);
      else        send_byte(8'(8'h41 + i - 26), 1'b0);
    end
    checks++; if (in_ready !== 1'b0 || msg_len !== 6'd32) $display("FAIL ovf_commit rdy=%b len=%0d want 0/32", in_ready, msg_len); else passed++;
    grab_frame();
    exp = "ABCDEF";
    checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL ovf_step0 text=%h want=%h", fr_text(), exp); else passed++;
    for (int s = 1; s <= 38; s++) begin
      grab_frame();
      if (s == 27) begin
        exp = "BCDEF ";
        checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL ovf_step27 text=%h want=%h", fr_text(), exp); else passed++;
      end else if (s == 37) begin
        exp = " ABCDE";
        checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL ovf_step37 text=%h want=%h", fr_text(), exp); else passed++;
      end else if (s == 38) begin
        exp = "ABCDEF";
        checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL ovf_wrap text=%h want=%h", fr_text(), exp); else passed++;
      end
    end
    do_clear();
  endtask

  task automatic test_boundary_reset();
    logic [47:0] exp;
    int n;
    bit seen;
    send_byte(8'h60, 1'b0);
    send_byte("a", 1'b0);
    send_byte(8'h7b, 1'b0);
    send_byte("z", 1'b1);
    grab_frame();
    exp = {8'h60, 8'h41, 8'h7b, 8'h5a, 8'h20, 8'h20};
    checks++; if (!fr_ok || fr_text() !== exp) $display("FAIL conv_frame text=%h want=%h", fr_text(), exp); else passed++;
    n = 0;
    while (char_load !== 1'b1 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (char_load !== 1'b1 || char_addr !== 3'd3) $display("FAIL mid_refresh load=%b addr=%0d want 1/3", char_load, char_addr); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (char_load !== 1'b0) $display("FAIL async_reset load=%b want=0", char_load); else passed++;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || msg_len !== 6'd0 || char_out !== 8'h00 || char_addr !== 3'd0) $display("FAIL post_reset rdy=%b busy=%b len=%0d out=%h addr=%0d want 1/0/0/00/0", in_ready, busy, msg_len, char_out, char_addr); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (char_load !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) $display("FAIL no_resume load seen=1 want=0"); else passed++;
  endtask

  initial begin
    test_reset();
    test_short_msg();
    test_hold_valid();
    test_clear();
    test_single_char();
    test_overflow();
    test_boundary_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
